halt_ctrl: RTL

Parametrised halt/run controller for the processor core. It replaces the single-bit sticky halt latch. It arbitrates up to NUM_SRC maskable halt sources plus an internal cycle-limit watchdog, drains the pipeline for a fixed number of cycles before declaring the core halted, and records the halt cause. It also supports resume and single-step. It sits between the decode/execute stages, which raise halt requests, and the top-level main loop, which polls `halt_program` and drives `run_en` into the fetch stage.

---
 rtl/halt_pkg.sv | 28 ++
 rtl/halt_ctrl_sat_counter.sv | 34 +++
 rtl/halt_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/halt_pkg.sv
`default_nettype none
// ============================================================================
// Package     : halt_pkg
// Description : Shared state encoding and halt-cause bit positions for halt_ctrl
// Revision    : 1.0
// ============================================================================
package halt_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    localparam int DRAIN_W = 8;

    // Cause vector layout: sources first, then the watchdog bit, then the step bit.
    function automatic int CAUSE_LIMIT(input int num_src);
        return num_src;
    endfunction

    function automatic int CAUSE_STEP(input int num_src);
        return num_src + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/halt_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter with enable, synchronous clear and saturation at all-ones
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : halt_ctrl
// Description : Halt/run controller: maskable halt sources, cycle-limit watchdog,
//               pipeline drain, halt cause recording, resume and single-step
// Revision    : 1.0
// ============================================================================
module halt_ctrl
    import halt_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   halt_req,
    input  logic [NUM_SRC-1:0]   halt_mask,
    input  logic [CNT_W-1:0]     cycle_limit,
    input  logic                 clr_count,
    input  logic                 step_mode,
    input  logic                 resume_req,
    output logic                 run_en,
    output logic                 halt_program,
    output logic [NUM_SRC+1:0]   halt_cause,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int                 c_LIM_BIT    = CAUSE_LIMIT(NUM_SRC);
    localparam int                 c_STEP_BIT   = CAUSE_STEP(NUM_SRC);
    localparam logic [DRAIN_W-1:0] c_DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] c_DRAIN_DEC  = DRAIN_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t               r_state,  w_state_nxt;
    logic [DRAIN_W-1:0]   r_drain,  w_drain_nxt;
    logic [NUM_SRC+1:0]   r_cause,  w_cause_nxt;
    logic [NUM_SRC-1:0]   w_unmasked;
    logic                 w_limit_hit;
    logic                 w_run;

    assign w_unmasked = halt_req & ~halt_mask;
    // Trigger one count early so exactly cycle_limit run cycles complete before run_en drops.
    assign w_limit_hit = (cycle_limit != '0) && (cycle_count >= (cycle_limit - c_CNT_ONE));
    assign w_run       = (r_state == ST_RUN) || (r_state == ST_STEP);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_run),
        .i_clr   (clr_count),
        .o_count (cycle_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_drain <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_RUN: begin
                if ((|w_unmasked) || w_limit_hit) begin
                    w_state_nxt                  = ST_DRAIN;
                    w_drain_nxt                  = c_DRAIN_LOAD;
                    w_cause_nxt                  = '0;
                    w_cause_nxt[NUM_SRC-1:0]     = w_unmasked;
                    w_cause_nxt[c_LIM_BIT]       = w_limit_hit;
                end
            end
            ST_DRAIN: begin
                if (r_drain == '0) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_drain_nxt = r_drain - c_DRAIN_DEC;
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    w_cause_nxt = '0;
                    w_state_nxt = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_STEP: begin
                w_state_nxt              = ST_DRAIN;
                w_drain_nxt              = c_DRAIN_LOAD;
                w_cause_nxt              = '0;
                w_cause_nxt[NUM_SRC-1:0] = w_unmasked;
                w_cause_nxt[c_STEP_BIT]  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign run_en       = w_run;
    assign halt_program = (r_state == ST_HALTED);
    assign halt_cause   = r_cause;

endmodule
`default_nettype wire
